uart_tx_framed: RTL and testbench

//   Parametrised UART transmitter: serialises one word per frame onto o_uart_tx.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_framed_if.sv | 11 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_framed.sv | 146 ++++++++++++++
 tb/tb_uart_tx_framed.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the framed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;
    localparam int CLKS_PER_BAUD_MIN = 2;

endpackage

// File: rtl/uart_tx_framed_if.sv
// Word handshake between a byte source (master) and the UART transmitter (slave).
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_ready;

    modport master (output i_valid, output i_data, input  o_ready);
    modport slave  (input  i_valid, input  i_data, output o_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BAUD-1 and flags the last count; i_clear realigns the phase.
module uart_baud_gen #(
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BAUD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_tick = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q + 1'b1;
        if (i_clear || o_tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
// Parity bit is present only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_framed_if.slave  s_if,
    output logic             o_busy,
    output logic             o_uart_tx
);
    if (CLKS_PER_BAUD < CLKS_PER_BAUD_MIN) begin : g_bad_cpb
        $error("uart_tx_framed: CLKS_PER_BAUD must be >= 2");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_db
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_sb
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_po
        $error("uart_tx_framed: PARITY_ODD must be 0 or 1");
    end

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    uart_tx_state_t       state_q, state_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic baud_tick;
    logic accept;
    logic frame_end;

    uart_baud_gen #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_baud (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (accept),
        .o_tick  (baud_tick)
    );

    // Ready also in the last cycle of the final stop bit so frames can run back-to-back.
    assign frame_end   = (state_q == STOP) && baud_tick && (stop_cnt_q == LAST_STOP);
    assign s_if.o_ready = (state_q == IDLE) || frame_end;
    assign accept      = s_if.i_valid && s_if.o_ready;
    assign o_busy      = busy_q;
    assign o_uart_tx   = tx_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (accept) begin
            state_d    = START;
            shift_d    = s_if.i_data;
            tx_d       = 1'b0;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = (^s_if.i_data) ^ (PARITY_ODD != 0);
`endif
        end else if (baud_tick) begin
            case (state_q)
                IDLE: ;
                START: begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
                DATA: begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // Datapath flops carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed; with UART_TX_PARITY_EN it runs the 7O2 parity frame instead of 8N1 frames.
module tb_uart_tx_framed;
`ifdef UART_TX_PARITY_EN
    localparam int DB = 7, SB = 2, PODD = 1, PB = 1;
`else
    localparam int DB = 8, SB = 1, PODD = 0, PB = 0;
`endif
    localparam int CPB   = 4;
    localparam int NBITS = 1 + DB + PB + SB;

    logic clk = 1'b0;
    logic rst;
    logic busy, tx;
    int   checks = 0, failures = 0, accepts = 0;

    always #5 clk = ~clk;

    uart_tx_framed_if #(.DATA_BITS(DB)) bus ();

    uart_tx_framed #(
        .CLKS_PER_BAUD (CPB),
        .DATA_BITS     (DB),
        .STOP_BITS     (SB),
        .PARITY_ODD    (PODD)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .s_if      (bus.slave),
        .o_busy    (busy),
        .o_uart_tx (tx)
    );

    always @(posedge clk) begin
        if (!rst && bus.i_valid && bus.o_ready) accepts = accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},    tx,          1);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_ready"}, bus.o_ready, 1);
    endtask

    // Called #1 after the acceptance edge; line[k] is the expected level of bit k of the frame.
    task automatic frame(input logic [15:0] line, input logic nv, input logic [DB-1:0] nd,
                         input int pulse_at, input string tag);
        int idx;
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                idx = k * CPB + c;
                check($sformatf("%s_tx_b%0d_c%0d", tag, k, c), tx, line[k]);
                check($sformatf("%s_busy_%0d", tag, idx), busy, 1);
                check($sformatf("%s_ready_%0d", tag, idx), bus.o_ready,
                      (k == NBITS - 1 && c == CPB - 1) ? 1 : 0);
                if (idx == 0) begin
                    bus.i_valid = nv;
                    bus.i_data  = nd;
                end
                if (idx == pulse_at) begin
                    bus.i_valid = 1'b1;
                    bus.i_data  = DB'(8'h3C);
                end
                if (pulse_at >= 0 && idx == pulse_at + 1) bus.i_valid = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = DB'(8'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("rst%0d", i));
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        step();
        step();
        check_idle("post_rst");
        check("post_rst_accepts", accepts, 0);

`ifndef UART_TX_PARITY_EN
        // Single frame 0xA5
        accepts     = 0;
        bus.i_data  = 8'hA5;
        bus.i_valid = 1'b1;
        check("t2_ready_pre", bus.o_ready, 1);
        step();
        frame(16'h034A, 1'b0, 8'h00, -1, "t2");
        check_idle("t2_end");
        check("t2_accepts", accepts, 1);

        // Back-to-back 0x00 then 0xFF with valid held
        accepts     = 0;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b1;
        step();
        frame(16'h0200, 1'b1, 8'hFF, -1, "t3a");
        frame(16'h03FE, 1'b0, 8'h00, -1, "t3b");
        check_idle("t3_end");
        check("t3_accepts", accepts, 2);

        // Mid-frame valid pulse with 0x3C is dropped
        accepts     = 0;
        bus.i_data  = 8'h69;
        bus.i_valid = 1'b1;
        step();
        frame(16'h02D2, 1'b0, 8'h00, 13, "t4");
        check_idle("t4_end");
        check("t4_accepts", accepts, 1);

        // Reset during data bit 3 of 0xF0, then a clean frame 0x5A
        accepts     = 0;
        bus.i_data  = 8'hF0;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        repeat (17) step();
        check("t5_tx_bit3", tx, 0);
        check("t5_busy_mid", busy, 1);
        rst = 1'b1;
        step();
        check_idle("t5_rst");
        rst = 1'b0;
        check("t5_accepts_a", accepts, 1);
        step();
        check_idle("t5_idle");
        bus.i_data  = 8'h5A;
        bus.i_valid = 1'b1;
        step();
        frame(16'h02B4, 1'b0, 8'h00, -1, "t5");
        check_idle("t5_end");
        check("t5_accepts_b", accepts, 2);
`else
        // 7 data bits, odd parity, 2 stop bits: 7'h07 -> parity 0, 11 bits
        accepts     = 0;
        bus.i_data  = 7'h07;
        bus.i_valid = 1'b1;
        step();
        frame(16'h060E, 1'b0, 7'h00, -1, "t6");
        check_idle("t6_end");
        check("t6_accepts", accepts, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
